conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter IMG_W, default 32, image width in pixels (legal range 3..1024).
REQ-002 Parameter IMG_H, default 32, image height in pixels (legal range 3..1024).
REQ-003 Parameter DATA_W, default 32, pixel width in bits (one image-RAM word).
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame.
REQ-007 in_valid  input  1  in_data holds a valid pixel.
REQ-008 in_data  input  DATA_W  pixel data, raster order.
REQ-009 in_ready  output  1  block accepts a pixel this cycle.
REQ-010 out_valid  output  1  window holds a valid 3x3 window.
REQ-011 out_ready  input  1  downstream MAC stage accepts the window.
REQ-012 window  output  9*DATA_W  3x3 window, w0 in bits [DATA_W-1:0] through w8 in the MSBs.
REQ-013 out_last  output  1  qualifies the final window of the frame.
REQ-014 done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE->RUN on start=1; the transition clears the col and row counters.
REQ-017 RUN->DONE when the last pixel (row IMG_H-1, col IMG_W-1) has been accepted and the last window has been accepted (out_valid & out_ready).
REQ-018 DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 A pixel transfer occurs when in_valid & in_ready.
REQ-021 in_ready = (state==RUN) & pixels-remaining & (!out_valid | out_ready).
REQ-022 Each transfer SHALL increment col; col wraps IMG_W-1->0 and increments row.
REQ-023 The line buffers SHALL hold the two previous rows; window columns SHALL shift left on each transfer.
REQ-024 A transfer of pixel p(r,c) with r>=2 and c>=2 SHALL load window on the next cycle and set out_valid the next cycle (latency 1).
REQ-025 Window layout: w(3i+j) = p(r-2+i, c-2+j) for i,j in 0..2.
REQ-026 Transfers with r<2 or c<2 SHALL update the line buffers and shift registers only, with no output.
REQ-027 out_valid SHALL clear on out_ready unless a new window loads the same cycle.
REQ-028 While out_valid=1 and out_ready=0, window and out_last SHALL hold stable.
REQ-029 out_last=1 only with the window whose bottom-right pixel is (IMG_H-1, IMG_W-1).
REQ-030 Windows per frame SHALL be exactly (IMG_W-2)*(IMG_H-2).
REQ-031 Pixel data SHALL pass unmodified (no arithmetic).
REQ-032 Counter widths SHALL be clog2(IMG_W) and clog2(IMG_H).

Reset
REQ-033 With rst=0 at a clock edge: state=IDLE, col=row=0, out_valid=0, out_last=0, done=0, in_ready=0, window=0.
REQ-034 Reset mid-frame SHALL abandon the frame; no done pulse is generated, and the next start begins a clean frame.
REQ-035 Line-buffer contents need not be cleared, because no window is emitted until two new rows have been written.

Structure
REQ-036 Package cnn_pkg SHALL hold DATA_W, the state enum (IDLE/RUN/DONE) and the window index constants.
REQ-037 One sub-module line_buffer (depth IMG_W, width DATA_W, 1 read/1 write per cycle) SHALL be instantiated twice.

Verification (IMG_W=4, IMG_H=4, pixels 0..15 in raster order)
REQ-038 Continuous stream with out_ready=1 -> first out_valid one cycle after pixel 10 is accepted, window {0,1,2,4,5,6,8,9,10}; 4 windows total.
REQ-039 Same stream -> last window {5,6,7,9,10,11,13,14,15} with out_last=1, then done=1 for one cycle, then IDLE.
REQ-040 out_ready=0 for 5 cycles while window {1,2,3,5,6,7,9,10,11} is valid -> window stable, in_ready=0, no pixel lost; resumes correctly.
REQ-041 rst=0 after pixel 7 -> all outputs 0; a new start with pixels 100..115 -> first window {100,101,102,104,105,106,108,109,110}.
REQ-042 start pulsed during RUN and in_valid asserted in IDLE -> both ignored (in_ready=0 in IDLE, frame unaffected).

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, FSM state codes and window index constants for the conv window generator
package cnn_pkg;
    localparam int DATA_W = 32;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN = 2'd1;
    localparam state_t DONE = 2'd2;
    localparam int WIN_N = 9;
    localparam int WIN_TL = 0;
    localparam int WIN_BR = 8;
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel input stream and 3x3 window output stream
interface conv_window_gen_if import cnn_pkg::*; #(parameter int DATA_W = cnn_pkg::DATA_W);
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic [WIN_N*DATA_W-1:0] window;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_last, window);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_last, window);
endinterface

// File: rtl/line_buffer.sv
// line_buffer: one image row of storage, read-before-write at a shared column address
module line_buffer #(
    parameter int DEPTH = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    assign rdata = mem[addr];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster pixel stream into a stream of 3x3 windows
module conv_window_gen import cnn_pkg::*; #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int DATA_W = cnn_pkg::DATA_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    state_t state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic more, xfer, load, last_px;
    logic [DATA_W-1:0] up1, up2;
    logic [DATA_W-1:0] sr [3][3];
    assign bus.in_ready = state == RUN && more && (!bus.out_valid || bus.out_ready);
    assign xfer = bus.in_valid && bus.in_ready;
    assign load = xfer && row >= RW'(2) && col >= CW'(2);
    assign last_px = row == ROW_MAX && col == COL_MAX;
    assign done = state == DONE;
    // lb_r1 holds the previous row; it cascades into lb_r2 so that one holds the row before
    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) lb_r1 (
        .clk(clk), .we(xfer), .addr(col), .wdata(bus.in_data), .rdata(up1)
    );
    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) lb_r2 (
        .clk(clk), .we(xfer), .addr(col), .wdata(up1), .rdata(up2)
    );
    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            assign bus.window[(3*i+j)*DATA_W +: DATA_W] = sr[i][j];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            col <= '0;
            row <= '0;
            more <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last <= 1'b0;
            sr <= '{default: '0};
        end else begin
            state <= state == IDLE ? (start ? RUN : IDLE)
                   : state == RUN ? (!more && bus.out_valid && bus.out_ready && bus.out_last ? DONE : RUN)
                   : IDLE;
            if (state == IDLE && start) begin
                col <= '0;
                row <= '0;
                more <= 1'b1;
            end else if (xfer) begin
                col <= col == COL_MAX ? '0 : col + CW'(1);
                row <= col == COL_MAX ? row + RW'(1) : row;
                more <= !last_px;
                for (int i = 0; i < 3; i++) begin
                    sr[i][0] <= sr[i][1];
                    sr[i][1] <= sr[i][2];
                end
                sr[0][2] <= up2;
                sr[1][2] <= up1;
                sr[2][2] <= bus.in_data;
            end
            bus.out_valid <= load || (bus.out_valid && !bus.out_ready);
            bus.out_last <= load ? last_px : bus.out_last && !bus.out_ready;
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for conv_window_gen on a 4x4 image
module tb_conv_window_gen;
    localparam int W = 4, H = 4, DW = 32, WB = 9 * DW;
    typedef struct {
        logic [WB-1:0] win;
        logic last;
    } exp_t;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, done;
    conv_window_gen_if #(.DATA_W(DW)) bus ();
    conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .bus(bus)
    );
    always #5 clk = ~clk;
    exp_t q[$];
    logic [DW-1:0] pix [H][W];
    int checks = 0, failures = 0, cyc = 0;
    int mr = 0, mc = 0, pidx = 0, nwin_f = 0, ndone = 0, acc10 = 0, stall_left = 0;
    bit first_seen = 0, stall_armed = 0, hold_chk = 0;
    logic [WB-1:0] held_win;
    logic held_last;

    task automatic check_eq(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [DW-1:0] d);
        exp_t e;
        logic ordy;
        @(negedge clk);
        if (stall_armed && bus.out_valid && nwin_f == 1) begin
            stall_left = 5;
            stall_armed = 0;
        end
        ordy = stall_left == 0;
        if (stall_left > 0) stall_left--;
        start = s;
        bus.in_valid = v;
        bus.in_data = d;
        bus.out_ready = ordy;
        #1;
        cyc++;
        if (hold_chk) begin
            check_eq("hold_window", bus.window, held_win);
            check_eq("hold_last", WB'(bus.out_last), WB'(held_last));
        end
        hold_chk = bus.out_valid && !ordy;
        held_win = bus.window;
        held_last = bus.out_last;
        if (bus.out_valid && !ordy) check_eq("stall_in_ready", WB'(bus.in_ready), '0);
        if (bus.out_valid && !first_seen) begin
            first_seen = 1;
            check_eq("first_latency", WB'(cyc), WB'(acc10 + 1));
        end
        if (bus.out_valid && ordy) begin
            if (q.size() == 0) check_eq("extra_window", WB'(1), '0);
            else begin
                e = q.pop_front();
                check_eq("window", bus.window, e.win);
                check_eq("out_last", WB'(bus.out_last), WB'(e.last));
                nwin_f++;
            end
        end
        if (v && bus.in_ready && pidx < W * H) begin
            pix[mr][mc] = d;
            if (pidx == 10) acc10 = cyc;
            if (mr >= 2 && mc >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.win[(3*i+j)*DW +: DW] = pix[mr-2+i][mc-2+j];
                e.last = mr == H - 1 && mc == W - 1;
                q.push_back(e);
            end
            pidx++;
            mc = mc == W - 1 ? 0 : mc + 1;
            if (mc == 0) mr++;
        end
        if (done) ndone++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", WB'(bus.out_valid), '0);
        check_eq("rst_out_last", WB'(bus.out_last), '0);
        check_eq("rst_done", WB'(done), '0);
        check_eq("rst_in_ready", WB'(bus.in_ready), '0);
        check_eq("rst_window", bus.window, '0);
        rst = 1'b1;
        hold_chk = 0;
    endtask

    task automatic run_frame(input int base, input int n, input bit stall, input bit poke);
        int k;
        q.delete();
        mr = 0; mc = 0; pidx = 0; nwin_f = 0; ndone = 0; acc10 = 0;
        first_seen = 0; stall_armed = stall; stall_left = 0; hold_chk = 0;
        step(1'b1, 1'b0, '0);
        for (k = 0; k < 200 && (pidx < n || q.size() > 0); k++)
            step(poke && k == 5, pidx < n, DW'(base + pidx));
        check_eq("frame_timeout", WB'(k < 200), WB'(1));
    endtask

    task automatic end_frame(input int nexp);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0);
        check_eq("done_pulses", WB'(ndone), WB'(1));
        check_eq("window_count", WB'(nwin_f), WB'(nexp));
        step(1'b0, 1'b1, DW'(77));
        check_eq("idle_in_ready", WB'(bus.in_ready), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        do_reset();
        step(1'b0, 1'b1, DW'(55));
        check_eq("pre_start_in_ready", WB'(bus.in_ready), '0);
        run_frame(0, 16, 0, 1);
        end_frame(4);
        run_frame(0, 16, 1, 0);
        end_frame(4);
        run_frame(0, 8, 0, 0);
        do_reset();
        ndone = 0;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0);
        check_eq("abort_no_done", WB'(ndone), '0);
        check_eq("abort_no_window", WB'(nwin_f), '0);
        run_frame(100, 16, 0, 0);
        end_frame(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
